// File: rtl/div_pkg.sv
// +----------------------------------------------------------------------+
// | div_pkg : shared types and sizing helpers for the sequential divider |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package div_pkg;

  localparam int DIV_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Iteration counter width; kept at least one bit for degenerate widths.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trial_sub.sv
// +----------------------------------------------------------------------+
// | trial_sub : ripple A + ~B + 1 subtractor, carry-out is not-borrow    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module trial_sub #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         carry_out
);

  logic [W:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    logic b_n;
    assign b_n          = ~b[i];
    assign diff[i]      = a[i] ^ b_n ^ carry[i];
    assign carry[i + 1] = (a[i] & b_n) | (a[i] & carry[i]) | (b_n & carry[i]);
  end

  assign carry_out = carry[W];

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// +----------------------------------------------------------------------+
// | seq_divider : restoring unsigned divider, one trial subtract / clock |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic [WIDTH:0]   rs;
  logic [WIDTH:0]   t;
  logic             no_borrow;
  logic             unused_t_msb;

  assign accept = start && (state_q != RUN);
  assign rs     = {r_q, q_q[WIDTH-1]};

  trial_sub #(
    .W(WIDTH + 1)
  ) u_trial_sub (
    .a        (rs),
    .b        ({1'b0, divisor_q}),
    .diff     (t),
    .carry_out(no_borrow)
  );

  // A non-borrowing difference is always below the divisor, so its MSB is zero.
  assign unused_t_msb = t[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      divisor_q <= '0;
      q_q       <= '0;
      r_q       <= '0;
      count_q   <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      divisor_q <= divisor_d;
      q_q       <= q_d;
      r_q       <= r_d;
      count_q   <= count_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) state_d = (divisor == '0) ? DONE : RUN;
        else       state_d = IDLE;
      end
      RUN:     if (count_q == '0) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    divisor_d = divisor_q;
    q_d       = q_q;
    r_d       = r_q;
    count_d   = count_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    if (accept) begin
      divisor_d = divisor;
      q_d       = dividend;
      r_d       = '0;
      count_d   = CNT_W'(WIDTH - 1);
      quot_d    = '0;
      rem_d     = '0;
      dbz_d     = 1'b0;
      if (divisor == '0) begin
        quot_d = '1;
        rem_d  = dividend;
        dbz_d  = 1'b1;
      end
    end else if (state_q == RUN) begin
      q_d     = {q_q[WIDTH-2:0], no_borrow};
      r_d     = no_borrow ? t[WIDTH-1:0] : rs[WIDTH-1:0];
      count_d = count_q - CNT_W'(1);
      if (count_q == '0) begin
        quot_d = q_d;
        rem_d  = r_d;
      end
    end
  end

  always_comb begin
    busy        = (state_q == RUN);
    done        = (state_q == DONE);
    quotient    = quot_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// +----------------------------------------------------------------------+
// | tb_seq_divider : scoreboard bench for seq_divider                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_seq_divider;

  localparam int W = 4;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         start    = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor  = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int r;
    int dz;
    int t0;
    int lat;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int t0);
    exp_t e;
    if (b == 0) begin
      e.q = (1 << W) - 1; e.r = a; e.dz = 1; e.lat = 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 0; e.lat = W + 1;
    end
    e.t0 = t0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 32'd1, 32'd0);
      end else begin
        got_e = sb.pop_front();
        check_eq("quotient", quotient, got_e.q);
        check_eq("remainder", remainder, got_e.r);
        check_eq("div_by_zero", div_by_zero, got_e.dz);
        check_eq("latency", cyc - got_e.t0, got_e.lat);
        check_eq("busy_in_done", busy, 32'd0);
      end
    end
  end

  task automatic launch(input int a, input int b, input bit expect_it);
    @(posedge clk); #1;
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    if (expect_it) sb.push_back(model(a, b, cyc));
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = W'($urandom_range(0, 15));
    divisor  = W'($urandom_range(0, 15));
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_pending"}, sb.size(), 32'd0);
    sb.delete();
  endtask

  int tbl[5][2] = '{'{15, 1}, '{5, 7}, '{15, 15}, '{0, 9}, '{13, 3}};

  initial begin
    int d0;
    int k;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 32'd0);
    check_eq("rst_done", done, 32'd0);
    check_eq("rst_quotient", quotient, 32'd0);
    check_eq("rst_remainder", remainder, 32'd0);
    check_eq("rst_dbz", div_by_zero, 32'd0);
    rst_n = 1'b1;

    launch(13, 3, 1'b1);
    check_eq("busy_after_accept", busy, 32'd1);
    drain("div_13_3");

    foreach (tbl[i]) begin
      launch(tbl[i][0], tbl[i][1], 1'b1);
      drain("div_table");
    end

    launch(9, 0, 1'b1);
    check_eq("busy_dz", busy, 32'd0);
    drain("div_9_0");

    // A start during RUN must be dropped, not queued.
    launch(12, 5, 1'b1);
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; dividend = 4'd7; divisor = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    drain("ignored_start");
    repeat (8) @(negedge clk);
    check_eq("ignored_start_dones", done_cnt - d0, 32'd1);

    // Back-to-back: next start presented in the DONE cycle.
    launch(14, 4, 1'b1);
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("b2b_first_done", done, 32'd1);
    start = 1'b1; dividend = 4'd11; divisor = 4'd3;
    sb.push_back(model(11, 3, cyc));
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("b2b_busy", busy, 32'd1);
    drain("back_to_back");

    // Asynchronous reset mid-RUN aborts with no done.
    launch(13, 3, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    d0 = done_cnt;
    check_eq("arst_busy", busy, 32'd0);
    check_eq("arst_done", done, 32'd0);
    check_eq("arst_quotient", quotient, 32'd0);
    check_eq("arst_remainder", remainder, 32'd0);
    check_eq("arst_dbz", div_by_zero, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("no_done_after_abort", done_cnt - d0, 32'd0);
    launch(6, 4, 1'b1);
    drain("div_6_4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed %0d compared, expected completion", n_cmp);
    $fatal(1);
  end

endmodule

`default_nettype wire
